// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: stalls upstream across a variable-latency data-memory access and feeds MEM/WB.
// Optional misaligned-access trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               regWriteFlagInput,
  input  logic               MemToRegInput,
  input  logic               memReadFlagInput,
  input  logic               memWriteFlagInput,
  input  logic               BranchsFlagInput,
  input  logic               JumpsFlagInput,
  input  logic               ZeroFlagInput,
  input  logic [31:0]        ResultInput,
  input  logic [31:0]        BInput,
  input  logic [31:0]        BranchAddressInput,
  input  logic [31:0]        JumpAddressInput,
  input  logic [4:0]         regDestAddressInput,
  mem_stage_if.master        dmem,
  output logic               stallOutput,
  output logic               pcSrcOutput,
  output logic [31:0]        pcTargetOutput,
  output logic               regWriteFlagOutput,
  output logic               MemToRegOutput,
  output logic               validOutput,
  output logic [31:0]        ReadDataOutput,
  output logic [31:0]        ResultOutput,
  output logic [4:0]         regDestAddressOutput,
  output logic               alignErrOutput
);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, nextState;

  logic        access;
  logic        misaligned;
  logic        startAccess;

  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic        capWe;
  logic        capLoad;
  logic        capRegWrite;
  logic        capMemToReg;
  logic [4:0]  capDest;
  logic [31:0] capResult;

  assign access = memReadFlagInput | memWriteFlagInput;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & (ResultInput[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign startAccess = (state == IDLE) & access & ~misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startAccess)   nextState = ACCESS;
      ACCESS:  if (dmem.dmem_ack) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    stallOutput   = 1'b0;
    pcSrcOutput   = 1'b0;
    case (state)
      IDLE: begin
        stallOutput = startAccess;
        pcSrcOutput = (BranchsFlagInput & ZeroFlagInput) | JumpsFlagInput;
      end
      ACCESS: begin
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = capWe;
        stallOutput   = ~dmem.dmem_ack;
      end
      default: ;
    endcase
  end

  assign pcTargetOutput  = JumpsFlagInput ? JumpAddressInput : BranchAddressInput;
  assign dmem.dmem_addr  = capAddr;
  assign dmem.dmem_wdata = capWdata;

  // Captured copies keep the bus stable even if upstream changes while we wait for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capAddr     <= '0;
      capWdata    <= '0;
      capWe       <= 1'b0;
      capLoad     <= 1'b0;
      capRegWrite <= 1'b0;
      capMemToReg <= 1'b0;
      capDest     <= '0;
      capResult   <= '0;
    end else if (startAccess) begin
      capAddr     <= {ResultInput[31:2], 2'b00};
      capWdata    <= BInput;
      capWe       <= memWriteFlagInput;
      capLoad     <= memReadFlagInput & ~memWriteFlagInput;
      capRegWrite <= regWriteFlagInput;
      capMemToReg <= MemToRegInput;
      capDest     <= regDestAddressInput;
      capResult   <= ResultInput;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteFlagOutput   <= 1'b0;
      MemToRegOutput       <= 1'b0;
      validOutput          <= 1'b0;
      ReadDataOutput       <= '0;
      ResultOutput         <= '0;
      regDestAddressOutput <= '0;
    end else begin
      regWriteFlagOutput   <= 1'b0;
      MemToRegOutput       <= 1'b0;
      validOutput          <= 1'b0;
      ReadDataOutput       <= '0;
      ResultOutput         <= '0;
      regDestAddressOutput <= '0;
      case (state)
        IDLE: begin
          if (!startAccess) begin
            regWriteFlagOutput   <= regWriteFlagInput & ~misaligned;
            MemToRegOutput       <= MemToRegInput;
            validOutput          <= 1'b1;
            ResultOutput         <= ResultInput;
            regDestAddressOutput <= regDestAddressInput;
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack) begin
            regWriteFlagOutput   <= capRegWrite;
            MemToRegOutput       <= capMemToReg;
            validOutput          <= 1'b1;
            ReadDataOutput       <= capLoad ? dmem.dmem_rdata : '0;
            ResultOutput         <= capResult;
            regDestAddressOutput <= capDest;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alignErrOutput <= 1'b0;
    else        alignErrOutput <= (state == IDLE) & misaligned;
  end
`else
  assign alignErrOutput = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations are hand-computed constants.
module tb_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        regWriteFlagInput, MemToRegInput, memReadFlagInput, memWriteFlagInput;
  logic        BranchsFlagInput, JumpsFlagInput, ZeroFlagInput;
  logic [31:0] ResultInput, BInput, BranchAddressInput, JumpAddressInput;
  logic [4:0]  regDestAddressInput;
  logic        stallOutput, pcSrcOutput;
  logic [31:0] pcTargetOutput;
  logic        regWriteFlagOutput, MemToRegOutput, validOutput;
  logic [31:0] ReadDataOutput, ResultOutput;
  logic [4:0]  regDestAddressOutput;
  logic        alignErrOutput;

  int errors = 0;
  int checks = 0;
  int stallCnt;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .regWriteFlagInput    (regWriteFlagInput),
    .MemToRegInput        (MemToRegInput),
    .memReadFlagInput     (memReadFlagInput),
    .memWriteFlagInput    (memWriteFlagInput),
    .BranchsFlagInput     (BranchsFlagInput),
    .JumpsFlagInput       (JumpsFlagInput),
    .ZeroFlagInput        (ZeroFlagInput),
    .ResultInput          (ResultInput),
    .BInput               (BInput),
    .BranchAddressInput   (BranchAddressInput),
    .JumpAddressInput     (JumpAddressInput),
    .regDestAddressInput  (regDestAddressInput),
    .dmem                 (dmem),
    .stallOutput          (stallOutput),
    .pcSrcOutput          (pcSrcOutput),
    .pcTargetOutput       (pcTargetOutput),
    .regWriteFlagOutput   (regWriteFlagOutput),
    .MemToRegOutput       (MemToRegOutput),
    .validOutput          (validOutput),
    .ReadDataOutput       (ReadDataOutput),
    .ResultOutput         (ResultOutput),
    .regDestAddressOutput (regDestAddressOutput),
    .alignErrOutput       (alignErrOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    regWriteFlagInput   = 1'b0;
    MemToRegInput       = 1'b0;
    memReadFlagInput    = 1'b0;
    memWriteFlagInput   = 1'b0;
    BranchsFlagInput    = 1'b0;
    JumpsFlagInput      = 1'b0;
    ZeroFlagInput       = 1'b0;
    ResultInput         = '0;
    BInput              = '0;
    BranchAddressInput  = '0;
    JumpAddressInput    = '0;
    regDestAddressInput = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req",    dmem.dmem_req,   0);
    check("rst_we",     dmem.dmem_we,    0);
    check("rst_addr",   dmem.dmem_addr,  0);
    check("rst_valid",  validOutput,     0);
    check("rst_result", ResultOutput,    0);
    check("rst_align",  alignErrOutput,  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU op passes through in one cycle
    tick();
    ResultInput = 32'h10; regWriteFlagInput = 1'b1; regDestAddressInput = 5'd5;
    @(negedge clk);
    check("alu_stall", stallOutput, 0);
    tick();
    check("alu_valid", validOutput, 1);
    check("alu_result", ResultOutput, 32'h10);
    check("alu_dest", regDestAddressOutput, 5);
    check("alu_regwrite", regWriteFlagOutput, 1);
    check("alu_rdata", ReadDataOutput, 0);

    // Load from 0x40, ack in the fourth ACCESS cycle
    memReadFlagInput = 1'b1; ResultInput = 32'h40; regDestAddressInput = 5'd7; MemToRegInput = 1'b1;
    stallCnt = 0;
    @(negedge clk);
    check("ld_idle_req", dmem.dmem_req, 0);
    if (stallOutput) stallCnt++;
    tick();
    check("ld_bubble", validOutput, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      check("ld_req", dmem.dmem_req, 1);
      check("ld_addr", dmem.dmem_addr, 32'h40);
      check("ld_we", dmem.dmem_we, 0);
      if (stallOutput) stallCnt++;
      tick();
      if (k < 3) check("ld_wait_valid", validOutput, 0);
    end
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    clearInputs();
    check("ld_stall_cycles", stallCnt, 4);
    check("ld_valid", validOutput, 1);
    check("ld_rdata", ReadDataOutput, 32'hDEADBEEF);
    check("ld_dest", regDestAddressOutput, 7);
    check("ld_memtoreg", MemToRegOutput, 1);
    tick();
    check("ld_after_rdata", ReadDataOutput, 0);
    check("ld_after_req", dmem.dmem_req, 0);

    // Store 0x1234 to 0x80, ack in first ACCESS cycle; a jump flag must not redirect during ACCESS
    memWriteFlagInput = 1'b1; BInput = 32'h1234; ResultInput = 32'h80;
    JumpsFlagInput = 1'b1; JumpAddressInput = 32'h300;
    @(negedge clk);
    check("st_idle_stall", stallOutput, 1);
    check("st_idle_pcsrc", pcSrcOutput, 1);
    tick();
    dmem.dmem_ack = 1'b1;
    @(negedge clk);
    check("st_req", dmem.dmem_req, 1);
    check("st_we", dmem.dmem_we, 1);
    check("st_wdata", dmem.dmem_wdata, 32'h1234);
    check("st_addr", dmem.dmem_addr, 32'h80);
    check("st_stall", stallOutput, 0);
    check("st_access_pcsrc", pcSrcOutput, 0);
    tick();
    dmem.dmem_ack = 1'b0;
    clearInputs();
    check("st_valid", validOutput, 1);
    check("st_rdata", ReadDataOutput, 0);
    check("st_result", ResultOutput, 32'h80);
    @(negedge clk);
    check("st_we_after", dmem.dmem_we, 0);

    // Read and write together behave as a write
    memReadFlagInput = 1'b1; memWriteFlagInput = 1'b1; ResultInput = 32'h84; BInput = 32'hCAFE;
    tick();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rw_we", dmem.dmem_we, 1);
    check("rw_wdata", dmem.dmem_wdata, 32'hCAFE);
    tick();
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    clearInputs();
    check("rw_valid", validOutput, 1);
    check("rw_rdata", ReadDataOutput, 0);

    // Branch / jump redirect
    tick();
    BranchsFlagInput = 1'b1; ZeroFlagInput = 1'b1; JumpsFlagInput = 1'b1;
    BranchAddressInput = 32'h100; JumpAddressInput = 32'h200;
    #1;
    check("bj_pcsrc", pcSrcOutput, 1);
    check("bj_target", pcTargetOutput, 32'h200);
    JumpsFlagInput = 1'b0; ZeroFlagInput = 1'b0;
    #1;
    check("br_nz_pcsrc", pcSrcOutput, 0);
    check("br_nz_target", pcTargetOutput, 32'h100);
    ZeroFlagInput = 1'b1;
    #1;
    check("br_z_pcsrc", pcSrcOutput, 1);
    clearInputs();

    // Misaligned load at 0x42
    tick();
    memReadFlagInput = 1'b1; ResultInput = 32'h42; regWriteFlagInput = 1'b1; regDestAddressInput = 5'd3;
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    check("al_stall", stallOutput, 0);
    check("al_req", dmem.dmem_req, 0);
    tick();
    clearInputs();
    check("al_err", alignErrOutput, 1);
    check("al_valid", validOutput, 1);
    check("al_regwrite", regWriteFlagOutput, 0);
    check("al_req_after", dmem.dmem_req, 0);
    tick();
    check("al_err_pulse", alignErrOutput, 0);
`else
    tick();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h55;
    @(negedge clk);
    check("al_addr", dmem.dmem_addr, 32'h40);
    check("al_err", alignErrOutput, 0);
    tick();
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    clearInputs();
    check("al_result", ResultOutput, 32'h42);
    check("al_rdata", ReadDataOutput, 32'h55);
`endif

    // Reset in the middle of an access abandons it; a late ack is ignored
    tick();
    memReadFlagInput = 1'b1; ResultInput = 32'h40; regWriteFlagInput = 1'b1; regDestAddressInput = 5'd9;
    tick();
    @(negedge clk);
    check("rs_req_before", dmem.dmem_req, 1);
    #2;
    clearInputs();
    rst_n = 1'b0;
    #1;
    check("rs_req", dmem.dmem_req, 0);
    check("rs_addr", dmem.dmem_addr, 0);
    check("rs_valid", validOutput, 0);
    check("rs_stall", stallOutput, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hBAD;
    tick();
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    check("rs_late_req", dmem.dmem_req, 0);
    check("rs_late_rdata", ReadDataOutput, 0);
    check("rs_late_dest", regDestAddressOutput, 0);
    check("rs_late_regwrite", regWriteFlagOutput, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 regWriteFlagInput, MemToRegInput, memReadFlagInput, memWriteFlagInput, BranchsFlagInput, JumpsFlagInput, ZeroFlagInput  in  1 each  control bits from the EX/MEM register.
REQ-005 ResultInput, BInput, BranchAddressInput, JumpAddressInput  in  32 each  ALU result/address, store data, branch target, jump target.
REQ-006 regDestAddressInput  in  5  destination register.
REQ-007 dmem_req, dmem_we  out  1 each  data-memory request and write enable; dmem_addr, dmem_wdata  out  32 each.
REQ-008 dmem_ack  in  1  access complete; dmem_rdata  in  32  read data, valid while dmem_ack=1.
REQ-009 stallOutput  out  1  holds EX/MEM and all upstream stages when 1.
REQ-010 pcSrcOutput  out  1  redirect PC; pcTargetOutput  out  32  redirect target.
REQ-011 MEM/WB outputs: regWriteFlagOutput, MemToRegOutput, validOutput  1 each; ReadDataOutput, ResultOutput  32 each; regDestAddressOutput  5.
REQ-012 alignErrOutput  out  1  misaligned-access flag.

Function
REQ-013 Access = memReadFlagInput | memWriteFlagInput.
REQ-014 The FSM SHALL have two states: IDLE and ACCESS.
REQ-015 IDLE, no access: the MEM/WB outputs SHALL load from the inputs at the next edge with validOutput=1 and ReadDataOutput=0; latency 1 cycle; stallOutput=0.
REQ-016 IDLE, access: stallOutput=1 combinationally; at the edge the block SHALL capture address, store data, control and destination, and enter ACCESS; MEM/WB SHALL load a bubble (validOutput=0, regWriteFlagOutput=0).
REQ-017 ACCESS: dmem_req=1, with dmem_addr, dmem_wdata and dmem_we (=captured memWrite) taken from the captured copies and held stable until dmem_ack.
REQ-018 ACCESS: stallOutput = ~dmem_ack; while dmem_ack=0, MEM/WB SHALL load bubbles.
REQ-019 ACCESS with dmem_ack=1: at the edge the FSM SHALL return to IDLE and MEM/WB SHALL load the captured fields with validOutput=1; ReadDataOutput = dmem_rdata for loads and 0 for stores.
REQ-020 Minimum load/store latency is 2 cycles (ack in the first ACCESS cycle); there SHALL be no upper bound.
REQ-021 dmem_ack SHALL be ignored in IDLE; dmem_req SHALL be 0 in IDLE.
REQ-022 pcSrcOutput = (BranchsFlagInput & ZeroFlagInput) | JumpsFlagInput, combinational, and forced to 0 while in ACCESS.
REQ-023 pcTargetOutput SHALL be JumpAddressInput when JumpsFlagInput=1, else BranchAddressInput; jump SHALL win if both flags are set.
REQ-024 Simultaneous read and write flags SHALL be treated as a write.

Reset
REQ-025 On rst_n=0, immediately and independent of clk: FSM=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; every MEM/WB output=0; alignErrOutput=0.
REQ-026 A reset asserted during ACCESS SHALL abandon the access; a late dmem_ack after reset SHALL be ignored.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN defined: an access with ResultInput[1:0]!=0 SHALL issue no request and SHALL not stall; alignErrOutput SHALL pulse 1 for one cycle (registered); MEM/WB SHALL load with validOutput=1, regWriteFlagOutput=0; latency 1 cycle.
REQ-028 Macro MEM_ALIGN_CHECK_EN undefined: dmem_addr[1:0] SHALL be forced to 00, the access SHALL proceed normally, and alignErrOutput SHALL be tied to 0.

Verification
REQ-029 ALU op: ResultInput=0x10, regWrite=1, dest=5 -> next cycle validOutput=1, ResultOutput=0x10, regDestAddressOutput=5, stallOutput never 1.
REQ-030 Load from 0x40 with ack after 3 ACCESS cycles, rdata=0xDEADBEEF -> stallOutput=1 for 4 cycles, dmem_addr stable at 0x40, ReadDataOutput=0xDEADBEEF with validOutput=1 once.
REQ-031 Store: BInput=0x1234 to 0x80, ack in the first ACCESS cycle -> dmem_we=1, dmem_wdata=0x1234 for one cycle, total latency 2 cycles, ReadDataOutput=0.
REQ-032 Branch with Zero=1 and Jump=1, targets 0x100/0x200 -> pcSrcOutput=1, pcTargetOutput=0x200; Branch with Zero=0 and no jump -> pcSrcOutput=0.
REQ-033 rst_n low during ACCESS, then ack pulse after release -> dmem_req drops immediately, all outputs 0, no MEM/WB valid generated.
REQ-034 With MEM_ALIGN_CHECK_EN, load at 0x42 -> no dmem_req, alignErrOutput=1 for one cycle, regWriteFlagOutput=0; without the macro -> dmem_addr=0x40.
